// File: rtl/alu_pkg.sv
// Shared ALU constants, one-hot op bit indices and the request bundle type
// used by ALU sharing blocks.
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CTRL_WIDTH = 12;
  localparam int unsigned TAG_WIDTH  = 4;

  localparam int unsigned OP_ADD  = 11;
  localparam int unsigned OP_SUB  = 10;
  localparam int unsigned OP_SLT  = 9;
  localparam int unsigned OP_SLTU = 8;
  localparam int unsigned OP_AND  = 7;
  localparam int unsigned OP_NOR  = 6;
  localparam int unsigned OP_OR   = 5;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SLL  = 3;
  localparam int unsigned OP_SRL  = 2;
  localparam int unsigned OP_SRA  = 1;
  localparam int unsigned OP_LUI  = 0;

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] op;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [TAG_WIDTH-1:0]  tag;
  } alu_req_t;

endpackage

// File: rtl/alu_rr_pick2.sv
// Two-way round-robin picker: grants the sole eligible requester, or the one
// that did not win last time when both are eligible. Purely combinational.
module alu_rr_pick2 (
  input  logic [1:0] eligible,
  input  logic       last_gnt,
  output logic [1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[0] = eligible[0] & (~eligible[1] | last_gnt);
    grant[1] = eligible[1] & (~eligible[0] | ~last_gnt);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external single-cycle ALU between two requesters with round-robin
// arbitration and per-requester response slots. Optional macro: ALU_ARB_ONEHOT_CHECK_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int unsigned CTRL_WIDTH = alu_pkg::CTRL_WIDTH,
  parameter int unsigned TAG_WIDTH  = alu_pkg::TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*CTRL_WIDTH-1:0] req_op,
  input  logic [2*DATA_WIDTH-1:0] req_src1,
  input  logic [2*DATA_WIDTH-1:0] req_src2,
  input  logic [2*TAG_WIDTH-1:0]  req_tag,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [2*DATA_WIDTH-1:0] rsp_result,
  output logic [2*TAG_WIDTH-1:0]  rsp_tag,
  output logic [1:0]              rsp_err,
  output logic [CTRL_WIDTH-1:0]   alu_control,
  output logic [DATA_WIDTH-1:0]   alu_src1,
  output logic [DATA_WIDTH-1:0]   alu_src2,
  input  logic [DATA_WIDTH-1:0]   alu_result
);

  logic [1:0] slot_free;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       any_gnt;
  logic       last_gnt;
  logic       op_legal;
  alu_req_t   req [2];
  alu_req_t   sel_req;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      req[i].op   = req_op[i*CTRL_WIDTH +: CTRL_WIDTH];
      req[i].src1 = req_src1[i*DATA_WIDTH +: DATA_WIDTH];
      req[i].src2 = req_src2[i*DATA_WIDTH +: DATA_WIDTH];
      req[i].tag  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  // A slot draining this cycle may be refilled in the same cycle.
  assign slot_free = ~rsp_valid | rsp_ready;
  assign eligible  = req_valid & slot_free & {2{~rst}};

  alu_rr_pick2 u_pick (
    .eligible (eligible),
    .last_gnt (last_gnt),
    .grant    (grant)
  );

  assign req_ready = grant;
  assign any_gnt   = |grant;
  assign sel_req   = grant[1] ? req[1] : req[0];

`ifdef ALU_ARB_ONEHOT_CHECK_EN
  assign op_legal = $onehot(sel_req.op);
`else
  assign op_legal = 1'b1;
`endif

  always_comb begin
    alu_control = '0;
    alu_src1    = '0;
    alu_src2    = '0;
    if (any_gnt) begin
      alu_control = op_legal ? sel_req.op : '0;
      alu_src1    = sel_req.src1;
      alu_src2    = sel_req.src2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt   <= 1'b1;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
    end else begin
      if (any_gnt) last_gnt <= grant[1];
      for (int unsigned i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid[i]                         <= 1'b1;
          rsp_result[i*DATA_WIDTH +: DATA_WIDTH] <= op_legal ? alu_result : '0;
          rsp_tag[i*TAG_WIDTH +: TAG_WIDTH]      <= sel_req.tag;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef ALU_ARB_ONEHOT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (grant[i]) rsp_err[i] <= ~op_legal;
      end
    end
  end
`else
  assign rsp_err = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [23:0] req_op;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [7:0]  req_tag;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_result;
  logic [7:0]  rsp_tag;
  logic [1:0]  rsp_err;
  logic [11:0] alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(12), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .alu_control(alu_control),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Reference ALU; an all-zero control yields a marker so forced-zero capture is visible.
  always_comb begin
    logic [4:0] sh;
    sh = alu_src1[10:6];
    if      (alu_control[11]) alu_result = alu_src1 + alu_src2;
    else if (alu_control[10]) alu_result = alu_src1 - alu_src2;
    else if (alu_control[9])  alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
    else if (alu_control[8])  alu_result = {31'd0, alu_src1 < alu_src2};
    else if (alu_control[7])  alu_result = alu_src1 & alu_src2;
    else if (alu_control[6])  alu_result = ~(alu_src1 | alu_src2);
    else if (alu_control[5])  alu_result = alu_src1 | alu_src2;
    else if (alu_control[4])  alu_result = alu_src1 ^ alu_src2;
    else if (alu_control[3])  alu_result = alu_src2 << sh;
    else if (alu_control[2])  alu_result = alu_src2 >> sh;
    else if (alu_control[1])  alu_result = $unsigned($signed(alu_src2) >>> sh);
    else if (alu_control[0])  alu_result = {alu_src2[15:0], 16'd0};
    else                      alu_result = 32'hDEADBEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [3:0] tg);
    req_op[11:0] = op; req_src1[31:0] = s1; req_src2[31:0] = s2; req_tag[3:0] = tg;
  endtask

  task automatic set1(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [3:0] tg);
    req_op[23:12] = op; req_src1[63:32] = s1; req_src2[63:32] = s2; req_tag[7:4] = tg;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_op = '0; req_src1 = '0; req_src2 = '0; req_tag = '0;
    set0(12'h800, 32'd1, 32'd1, 4'd1);
    set1(12'h800, 32'd2, 32'd2, 4'd2);
    tick(); tick();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_alu_control", alu_control, 12'h000);
    chk("rst_alu_src1", alu_src1, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_err", rsp_err, 2'b00);
    chk("rst_rsp_result", rsp_result, 64'd0);

    // 1: req0 ADD alone
    rst = 1'b0; req_valid = 2'b01;
    set0(12'h800, 32'd5, 32'd7, 4'd3);
    #1;
    chk("t1_req_ready", req_ready, 2'b01);
    chk("t1_alu_control", alu_control, 12'h800);
    chk("t1_alu_src2", alu_src2, 32'd7);
    tick();
    req_valid = 2'b00;
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_result", rsp_result[31:0], 32'd12);
    chk("t1_tag", rsp_tag[3:0], 4'd3);
    #1;
    chk("t1_idle_ready", req_ready, 2'b00);
    chk("t1_idle_src1", alu_src1, 32'd0);

    // 2: alternate grants with both valid, rsp_ready=11
    rst = 1'b1; tick(); rst = 1'b0;
    rsp_ready = 2'b11; req_valid = 2'b11;
    set0(12'h400, 32'd10, 32'd3, 4'd1);
    set1(12'h200, 32'hFFFFFFFF, 32'd1, 4'd2);
    #1; chk("t2_grant_a", req_ready, 2'b01);
    tick();
    chk("t2_valid_a", rsp_valid, 2'b01);
    chk("t2_res0_a", rsp_result[31:0], 32'd7);
    chk("t2_tag0_a", rsp_tag[3:0], 4'd1);
    #1; chk("t2_grant_b", req_ready, 2'b10);
    chk("t2_alu_b", alu_control, 12'h200);
    tick();
    chk("t2_valid_b", rsp_valid, 2'b10);
    chk("t2_res1_b", rsp_result[63:32], 32'd1);
    chk("t2_tag1_b", rsp_tag[7:4], 4'd2);
    #1; chk("t2_grant_c", req_ready, 2'b01);
    tick();
    chk("t2_valid_c", rsp_valid, 2'b01);
    #1; chk("t2_grant_d", req_ready, 2'b10);
    tick();
    chk("t2_valid_d", rsp_valid, 2'b10);

    // 3: slot 0 back-pressured
    rsp_ready = 2'b10;
    #1; chk("t3_grant_e", req_ready, 2'b01);
    tick();
    chk("t3_valid_e", rsp_valid, 2'b01);
    set0(12'h400, 32'd10, 32'd3, 4'd7);
    #1; chk("t3_grant_f", req_ready, 2'b10);
    tick();
    chk("t3_valid_f", rsp_valid, 2'b11);
    #1; chk("t3_grant_g", req_ready, 2'b10);
    tick();
    chk("t3_hold_res0", rsp_result[31:0], 32'd7);
    chk("t3_hold_tag0", rsp_tag[3:0], 4'd1);
    rsp_ready = 2'b11;
    #1; chk("t3_reenable", req_ready, 2'b01);
    tick();
    chk("t3_new_tag0", rsp_tag[3:0], 4'd7);
    chk("t3_valid_h", rsp_valid, 2'b01);

    // 4: both slots full, then reset
    rsp_ready = 2'b00;
    #1; chk("t4_fill1", req_ready, 2'b10);
    tick();
    chk("t4_full", rsp_valid, 2'b11);
    #1;
    chk("t4_no_ready", req_ready, 2'b00);
    chk("t4_alu_idle", alu_control, 12'h000);
    chk("t4_src1_idle", alu_src1, 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_rst_valid", rsp_valid, 2'b00);
    chk("t4_rst_result", rsp_result, 64'd0);
    chk("t4_rst_tag", rsp_tag, 8'd0);
    #1; chk("t4_first_contention", req_ready, 2'b01);
    tick();

    // 5: SRA on req1, then drain-and-refill
    req_valid = 2'b10;
    set1(12'h002, 32'h00000100, 32'h80000000, 4'd5);
    #1; chk("t5_grant", req_ready, 2'b10);
    tick();
    chk("t5_valid", rsp_valid, 2'b11);
    chk("t5_sra4", rsp_result[63:32], 32'hF8000000);
    chk("t5_tag", rsp_tag[7:4], 4'd5);
    rsp_ready = 2'b10;
    set1(12'h002, 32'h00000200, 32'h80000000, 4'd9);
    #1; chk("t5_refill_grant", req_ready, 2'b10);
    tick();
    chk("t5_refill_valid", rsp_valid, 2'b11);
    chk("t5_sra8", rsp_result[63:32], 32'hFF800000);
    chk("t5_new_tag", rsp_tag[7:4], 4'd9);

    // 6: non-one-hot op on req0
    rsp_ready = 2'b11; req_valid = 2'b01;
    set0(12'hC00, 32'd5, 32'd7, 4'd4);
    #1; chk("t6_accept", req_ready, 2'b01);
`ifdef ALU_ARB_ONEHOT_CHECK_EN
    chk("t6_alu_control", alu_control, 12'h000);
`else
    chk("t6_alu_control", alu_control, 12'hC00);
`endif
    tick();
    chk("t6_valid", rsp_valid, 2'b01);
    chk("t6_tag", rsp_tag[3:0], 4'd4);
`ifdef ALU_ARB_ONEHOT_CHECK_EN
    chk("t6_err", rsp_err, 2'b01);
    chk("t6_result", rsp_result[31:0], 32'd0);
`else
    chk("t6_err", rsp_err, 2'b00);
`endif
    set0(12'h001, 32'd0, 32'h00001234, 4'd6);
    tick();
    chk("t6_lui", rsp_result[31:0], 32'h12340000);
    chk("t6_err_clear", rsp_err, 2'b00);
    req_valid = 2'b00;
    tick();
    chk("t6_drained", rsp_valid, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
